// File: rtl/dvp_source_emulator_if.sv
// Camera-side DVP pin bundle: pixel clock, frame/line syncs and the 8-bit data bus.
interface dvp_source_emulator_if;
  logic       cam_xclk;
  logic       cam_vsync;
  logic       cam_href;
  logic [7:0] cam_dat;

  // Sensor side drives the pins.
  modport master (
    output cam_xclk,
    output cam_vsync,
    output cam_href,
    output cam_dat
  );

  // Capture side samples the pins.
  modport slave (
    input cam_xclk,
    input cam_vsync,
    input cam_href,
    input cam_dat
  );
endinterface

// File: rtl/dvp_source_emulator.sv
// OV-class DVP sensor emulator: streams vsync/href framed test patterns on a clk/2 pixel clock.
// The syncs and data change only when cam_xclk falls, so a sink sampling on the rising edge of
// cam_xclk always sees stable values.
module dvp_source_emulator #(
  parameter int unsigned H_ACTIVE        = 320,
  parameter int unsigned BYTES_PER_PIXEL = 2,
  parameter int unsigned H_BLANK         = 144,
  parameter int unsigned V_LINES         = 240,
  parameter int unsigned VSYNC_LINES     = 3,
  parameter int unsigned V_BACK          = 17,
  parameter int unsigned V_FRONT         = 10
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        enable,
  input  logic [1:0]                  pattern_sel,
  input  logic [7:0]                  const_byte,
  dvp_source_emulator_if.master       cam,
  output logic                        frame_done,
  output logic [15:0]                 frame_count
);

  localparam int unsigned H_BYTES = H_ACTIVE * BYTES_PER_PIXEL;
  localparam int unsigned LP      = H_BYTES + H_BLANK;
  localparam int unsigned BX_W    = (LP > 1) ? $clog2(LP) : 1;
  localparam int unsigned BXE_W   = BX_W + 1;
  localparam int unsigned LY_A    = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int unsigned LY_B    = (V_LINES > V_FRONT) ? V_LINES : V_FRONT;
  localparam int unsigned LY_MAX  = (LY_A > LY_B) ? LY_A : LY_B;
  localparam int unsigned LY_W    = (LY_MAX > 1) ? $clog2(LY_MAX) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_e;

  state_e            state_q, state_d;
  logic [BX_W-1:0]   bx_q, bx_d;
  logic [LY_W-1:0]   ly_q, ly_d;
  logic [1:0]        pat_q, pat_d;
  logic              xclk_q;
  logic              vsync_q, vsync_d;
  logic              href_q, href_d;
  logic [7:0]        dat_q, dat_d;
  logic              done_q;
  logic [15:0]       count_q;

  logic              tick_c;
  logic              line_end_c;
  logic              last_line_c;
  logic              start_c;
  logic              frame_end_c;
  int unsigned       lines_c;
  logic [7:0]        x8;
  logic [7:0]        y8;

  // A tick is the edge on which the pixel clock falls.
  assign tick_c     = xclk_q;
  assign line_end_c = (bx_q == BX_W'(LP - 1));

  // Line periods spent in the current region.
  always_comb begin
    lines_c = 0;
    case (state_q)
      ST_VSYNC:  lines_c = VSYNC_LINES;
      ST_VBACK:  lines_c = V_BACK;
      ST_ACTIVE: lines_c = V_LINES;
      ST_VFRONT: lines_c = V_FRONT;
      default:   lines_c = 0;
    endcase
    last_line_c = ((32'(ly_q) + 32'd1) == lines_c);
  end

  // State register and position counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      bx_q    <= '0;
      ly_q    <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      ly_q    <= ly_d;
      pat_q   <= pat_d;
    end
  end

  // Next position in the frame; empty regions are skipped without spending a tick.
  always_comb begin
    state_d     = state_q;
    bx_d        = bx_q;
    ly_d        = ly_q;
    start_c     = 1'b0;
    frame_end_c = 1'b0;
    if (tick_c) begin
      if (state_q == ST_IDLE) begin
        if (enable) begin
          start_c = 1'b1;
          state_d = ST_VSYNC;
        end
      end else begin
        bx_d = line_end_c ? '0 : bx_q + BX_W'(1);
        if (line_end_c) begin
          if (last_line_c) begin
            ly_d = '0;
            case (state_q)
              ST_VSYNC:  state_d = (V_BACK != 0) ? ST_VBACK : ST_ACTIVE;
              ST_VBACK:  state_d = ST_ACTIVE;
              ST_ACTIVE: begin
                if (V_FRONT != 0) state_d = ST_VFRONT;
                else              frame_end_c = 1'b1;
              end
              default:   frame_end_c = 1'b1;
            endcase
          end else begin
            ly_d = ly_q + LY_W'(1);
          end
        end
      end
      if (frame_end_c) begin
        if (enable) begin
          start_c = 1'b1;
          state_d = ST_VSYNC;
        end else begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  // Pin values for the next position; the pattern is re-latched only at frame start.
  always_comb begin
    pat_d   = start_c ? pattern_sel : pat_q;
    x8      = 8'(bx_d);
    y8      = 8'(ly_d);
    vsync_d = (state_d == ST_VSYNC);
    href_d  = (state_d == ST_ACTIVE) && ({1'b0, bx_d} < BXE_W'(H_BYTES));
    dat_d   = 8'h00;
    if (href_d) begin
      case (pat_d)
        2'd0:    dat_d = x8;
        2'd1:    dat_d = y8;
        2'd2:    dat_d = (x8[3] ^ y8[3]) ? 8'hFF : 8'h00;
        default: dat_d = const_byte;
      endcase
    end
  end

  // Pixel clock, pin registers (updated on ticks only) and frame bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      xclk_q  <= 1'b0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      dat_q   <= 8'h00;
      done_q  <= 1'b0;
      count_q <= 16'h0000;
    end else begin
      xclk_q <= ~xclk_q;
      done_q <= tick_c & frame_end_c;
      if (tick_c) begin
        vsync_q <= vsync_d;
        href_q  <= href_d;
        dat_q   <= dat_d;
      end
      if (tick_c && frame_end_c) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  assign cam.cam_xclk  = xclk_q;
  assign cam.cam_vsync = vsync_q;
  assign cam.cam_href  = href_q;
  assign cam.cam_dat   = dat_q;
  assign frame_done    = done_q;
  assign frame_count   = count_q;

endmodule

// File: tb/tb_dvp_source_emulator.sv
// Bench for the DVP source emulator: frame-offset reference model, rising-edge capture sink,
// sync-timing monitors and directed frame scenarios.
module tb_dvp_source_emulator;

  localparam int HA    = 4;
  localparam int BPP   = 2;
  localparam int HBL   = 3;
  localparam int VL    = 3;
  localparam int VSL   = 1;
  localparam int VB    = 1;
  localparam int VF    = 1;
  localparam int HBY   = HA * BPP;
  localparam int LP    = HBY + HBL;
  localparam int FRAME = (VSL + VB + VL + VF) * LP;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [7:0]  const_byte = 8'h00;
  logic        frame_done;
  logic [15:0] frame_count;

  dvp_source_emulator_if cam_if ();

  dvp_source_emulator #(
    .H_ACTIVE(HA), .BYTES_PER_PIXEL(BPP), .H_BLANK(HBL), .V_LINES(VL),
    .VSYNC_LINES(VSL), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .pattern_sel(pattern_sel),
    .const_byte(const_byte),
    .cam(cam_if),
    .frame_done(frame_done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Pin values at offset k ticks from the vsync rise of a frame.
  function automatic logic [9:0] model_out(input int k, input logic [1:0] pat, input logic [7:0] cb);
    int a, x, y;
    logic vs, hr;
    logic [7:0] d;
    vs = (k < VSL * LP);
    a  = k - (VSL + VB) * LP;
    hr = 1'b0;
    d  = 8'h00;
    if (a >= 0 && a < VL * LP && (a % LP) < HBY) begin
      hr = 1'b1;
      x  = a % LP;
      y  = a / LP;
      case (pat)
        2'd0:    d = 8'(x);
        2'd1:    d = 8'(y);
        2'd2:    d = (((x / 8) + (y / 8)) % 2 == 1) ? 8'hFF : 8'h00;
        default: d = cb;
      endcase
    end
    return {vs, hr, d};
  endfunction

  // Reference model: frame offset counter advanced on every pixel-clock fall.
  logic        m_xclk, m_in, m_vs, m_hr, m_done;
  logic [7:0]  m_dat;
  logic [1:0]  m_pat;
  logic [15:0] m_cnt;
  int          m_k;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_xclk <= 1'b0; m_in <= 1'b0; m_k <= 0; m_pat <= 2'd0;
      m_cnt <= 16'd0; m_done <= 1'b0; {m_vs, m_hr, m_dat} <= 10'd0;
    end else begin
      m_xclk <= ~m_xclk;
      m_done <= 1'b0;
      if (m_xclk) begin
        if (m_in && m_k == FRAME - 1) begin
          m_done <= 1'b1;
          m_cnt  <= m_cnt + 16'd1;
        end
        if (!m_in || m_k == FRAME - 1) begin
          if (enable) begin
            m_in <= 1'b1; m_k <= 0; m_pat <= pattern_sel;
            {m_vs, m_hr, m_dat} <= model_out(0, pattern_sel, const_byte);
          end else begin
            m_in <= 1'b0; m_k <= 0;
            {m_vs, m_hr, m_dat} <= 10'd0;
          end
        end else begin
          m_k <= m_k + 1;
          {m_vs, m_hr, m_dat} <= model_out(m_k + 1, m_pat, const_byte);
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("xclk",        32'(cam_if.cam_xclk),  32'(m_xclk));
    check("vsync",       32'(cam_if.cam_vsync), 32'(m_vs));
    check("href",        32'(cam_if.cam_href),  32'(m_hr));
    check("dat",         32'(cam_if.cam_dat),   32'(m_dat));
    check("frame_done",  32'(frame_done),       32'(m_done));
    check("frame_count", 32'(frame_count),      32'(m_cnt));
  end

  // Capture sink: bytes taken on the rising pixel clock while href is high.
  logic [7:0] cap_q[$];
  always @(posedge cam_if.cam_xclk) begin
    if (cam_if.cam_href) cap_q.push_back(cam_if.cam_dat);
  end

  // Sync timing monitors, measured in clk cycles.
  int   cyc = 0, vs_cnt = 0, vs_width = 0, vs_rise = 0, vs_period = 0, href_delay = 0;
  logic vs_prev = 1'b0, hr_prev = 1'b0, hd_pend = 1'b0;
  always @(negedge clk) begin
    cyc     <= cyc + 1;
    vs_prev <= cam_if.cam_vsync;
    hr_prev <= cam_if.cam_href;
    vs_cnt  <= cam_if.cam_vsync ? vs_cnt + 1 : 0;
    if (vs_prev && !cam_if.cam_vsync) vs_width <= vs_cnt;
    if (!vs_prev && cam_if.cam_vsync) begin
      vs_period <= cyc - vs_rise;
      vs_rise   <= cyc;
      hd_pend   <= 1'b1;
    end else if (hd_pend && !hr_prev && cam_if.cam_href) begin
      href_delay <= cyc - vs_rise;
      hd_pend    <= 1'b0;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (frame_done !== 1'b1 && n < budget);
    check("frame_done_seen", 32'(frame_done), 32'd1);
  endtask

  task automatic wait_vs_rise(input int budget);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (cam_if.cam_vsync !== 1'b1 && n < budget);
    check("vsync_rise_seen", 32'(cam_if.cam_vsync), 32'd1);
  endtask

  initial begin
    // Reset values, then idle with enable low.
    #2 resetn = 1'b0;
    #1;
    check("rst_xclk",  32'(cam_if.cam_xclk),  32'd0);
    check("rst_vsync", 32'(cam_if.cam_vsync), 32'd0);
    check("rst_href",  32'(cam_if.cam_href),  32'd0);
    check("rst_dat",   32'(cam_if.cam_dat),   32'd0);
    check("rst_count", 32'(frame_count),      32'd0);
    clks(3);
    resetn = 1'b1;
    clks(50);
    check("idle_count", 32'(frame_count),      32'd0);
    check("idle_vsync", 32'(cam_if.cam_vsync), 32'd0);

    // Single frame, pattern 0, enable pulsed for one tick.
    cap_q.delete();
    pattern_sel = 2'd0;
    enable = 1'b1;
    clks(2);
    enable = 1'b0;
    wait_done(200);
    check("p0_vsync_width", 32'(vs_width),    32'd22);
    check("p0_href_delay",  32'(href_delay),  32'd44);
    check("p0_count",       32'(frame_count), 32'd1);
    check("p0_cap_size",    32'(cap_q.size()), 32'd24);
    for (int i = 0; i < cap_q.size() && i < 24; i++) check("p0_cap_byte", 32'(cap_q[i]), 32'(i % 8));
    clks(20);
    check("p0_idle_vsync", 32'(cam_if.cam_vsync), 32'd0);

    // Three back-to-back frames, checkerboard pattern (all zero for this geometry).
    cap_q.delete();
    pattern_sel = 2'd2;
    enable = 1'b1;
    wait_done(300);
    wait_done(300);
    enable = 1'b0;
    wait_done(300);
    check("p2_vsync_period", 32'(vs_period),   32'd132);
    check("p2_count",        32'(frame_count), 32'd4);
    check("p2_cap_size",     32'(cap_q.size()), 32'd72);
    for (int i = 0; i < cap_q.size() && i < 72; i++) check("p2_cap_byte", 32'(cap_q[i]), 32'd0);

    // Pattern latched at frame start: mid-frame change only affects the next frame.
    cap_q.delete();
    pattern_sel = 2'd3;
    const_byte  = 8'hA5;
    enable = 1'b1;
    clks(20);
    pattern_sel = 2'd1;
    wait_done(300);
    enable = 1'b0;
    wait_done(300);
    check("latch_count",    32'(frame_count), 32'd6);
    check("latch_cap_size", 32'(cap_q.size()), 32'd48);
    for (int i = 0; i < cap_q.size() && i < 48; i++)
      check("latch_cap_byte", 32'(cap_q[i]), (i < 24) ? 32'hA5 : 32'((i - 24) / 8));

    // Reset asserted mid-line at line 1, byte 5.
    pattern_sel = 2'd0;
    enable = 1'b1;
    wait_vs_rise(20);
    clks(76);
    check("mid_href", 32'(cam_if.cam_href), 32'd1);
    check("mid_dat",  32'(cam_if.cam_dat),  32'd5);
    #2 resetn = 1'b0;
    #1;
    check("arst_vsync", 32'(cam_if.cam_vsync), 32'd0);
    check("arst_href",  32'(cam_if.cam_href),  32'd0);
    check("arst_dat",   32'(cam_if.cam_dat),   32'd0);
    check("arst_xclk",  32'(cam_if.cam_xclk),  32'd0);
    check("arst_count", 32'(frame_count),      32'd0);
    clks(3);
    resetn = 1'b1;
    wait_vs_rise(20);
    check("restart_count", 32'(frame_count), 32'd0);
    wait_done(200);
    check("restart_done_count", 32'(frame_count), 32'd1);
    enable = 1'b0;
    clks(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
